// File: rtl/npu_sdram_burst_master_if.sv
// Avalon-MM bus bundle between the NPU burst master and the f2h_sdram0 port.
interface npu_sdram_burst_master_if #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int BE_W    = 16,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]  avm_address;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_read;
  logic               avm_write;
  logic [DATA_W-1:0]  avm_writedata;
  logic [BE_W-1:0]    avm_byteenable;
  logic               avm_waitrequest;
  logic [DATA_W-1:0]  avm_readdata;
  logic               avm_readdatavalid;

  modport master (
    output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/npu_sdram_burst_master.sv
// Avalon-MM burst initiator for f2h_sdram0: splits block commands into bursts, buffers read data.
// Optional SDRAM_PERF_CNT_EN adds stall/beat performance counters.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// RD_REQ  | issuing read bursts as FIFO credit allows
// WR_BEAT | pulling write stream beats onto the bus
// DRAIN   | all reads issued, waiting for data to leave the FIFO
// FIN     | done pulse, back to IDLE next cycle
module npu_sdram_burst_master #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int BE_W       = 16,
  parameter int BURST_W    = 8,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  npu_sdram_burst_master_if.master bus
`ifdef SDRAM_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_beat_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_BEAT, DRAIN, FIN} state_t;
  state_t state;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining, burst_left;
  logic [LEN_W-1:0]  blen, rem_after, nblen;
  logic [CNT_W-1:0]  outstanding, fifo_count, out_next, cnt_next;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [31:0]       used;
  logic              push, pop, rd_issue, credit_now, credit_next;
  logic              wr_more, wr_take, wr_done_beat, cmd_acc;

  assign blen      = (remaining > MAX_LEN) ? MAX_LEN : remaining;
  assign rem_after = remaining - blen;
  assign nblen     = (rem_after > MAX_LEN) ? MAX_LEN : rem_after;

  // Beats with nothing outstanding are stale returns from before a reset.
  assign push     = bus.avm_readdatavalid && (outstanding != '0);
  assign rd_valid = (fifo_count != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = fifo_mem[rptr];
  assign rd_issue = (state == RD_REQ) && bus.avm_read && !bus.avm_waitrequest;

  // Credit counts both buffered and in-flight beats; ignoring a same-cycle pop keeps it conservative.
  assign used        = 32'(fifo_count) + 32'(outstanding);
  assign credit_now  = (used + 32'(blen)) <= 32'(FIFO_DEPTH);
  assign credit_next = (used + 32'(blen) + 32'(nblen)) <= 32'(FIFO_DEPTH);

  assign wr_more      = (remaining != '0) || (burst_left != '0);
  assign wr_ready     = (state == WR_BEAT) && wr_more && (!bus.avm_write || !bus.avm_waitrequest);
  assign wr_take      = wr_valid && wr_ready;
  assign wr_done_beat = bus.avm_write && !bus.avm_waitrequest;
  assign cmd_acc      = cmd_valid && cmd_ready;

  assign bus.avm_byteenable = '1;

  always_comb begin
    out_next = outstanding;
    if (rd_issue) out_next = out_next + CNT_W'(blen);
    if (push)     out_next = out_next - CNT_W'(1);
    cnt_next = fifo_count;
    if (push) cnt_next = cnt_next + CNT_W'(1);
    if (pop)  cnt_next = cnt_next - CNT_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wptr] <= bus.avm_readdata;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state              <= IDLE;
      cmd_ready          <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      addr               <= '0;
      remaining          <= '0;
      burst_left         <= '0;
      outstanding        <= '0;
      fifo_count         <= '0;
      wptr               <= '0;
      rptr               <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_burstcount <= '0;
      bus.avm_writedata  <= '0;
    end else begin
      outstanding <= out_next;
      fifo_count  <= cnt_next;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_acc) begin
            addr       <= cmd_addr;
            remaining  <= cmd_len;
            burst_left <= '0;
            cmd_ready  <= 1'b0;
            if (cmd_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= cmd_write ? WR_BEAT : RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!bus.avm_read) begin
            if (credit_now) begin
              bus.avm_read       <= 1'b1;
              bus.avm_address    <= addr;
              bus.avm_burstcount <= BURST_W'(blen);
            end
          end else if (!bus.avm_waitrequest) begin
            addr      <= addr + ADDR_W'(blen);
            remaining <= rem_after;
            if (rem_after == '0) begin
              bus.avm_read <= 1'b0;
              state        <= DRAIN;
            end else if (credit_next) begin
              bus.avm_address    <= addr + ADDR_W'(blen);
              bus.avm_burstcount <= BURST_W'(nblen);
            end else begin
              bus.avm_read <= 1'b0;
            end
          end
        end
        WR_BEAT: begin
          if (wr_take) begin
            bus.avm_write     <= 1'b1;
            bus.avm_writedata <= wr_data;
            if (burst_left == '0) begin
              bus.avm_address    <= addr;
              bus.avm_burstcount <= BURST_W'(blen);
              burst_left         <= blen - LEN_W'(1);
              addr               <= addr + ADDR_W'(blen);
              remaining          <= rem_after;
            end else begin
              burst_left <= burst_left - LEN_W'(1);
            end
          end else if (wr_done_beat) begin
            bus.avm_write <= 1'b0;
            if (!wr_more) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Finish in the same cycle the last beat leaves so done lands one cycle later.
          if (out_next == '0 && cnt_next == '0) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_PERF_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || cmd_acc) begin
      perf_stall_cnt <= '0;
      perf_beat_cnt  <= '0;
    end else begin
      if ((bus.avm_read || bus.avm_write) && bus.avm_waitrequest && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if ((push || wr_done_beat) && perf_beat_cnt != '1)
        perf_beat_cnt <= perf_beat_cnt + 32'd1;
    end
  end
`endif
endmodule
